// File: rtl/acondicionador_entradas.sv
// Two-channel button conditioner: 2-flop synchronizer, per-channel debounce FSM, registered outputs.
// Define ACONDICIONADOR_PULSO_EN to enable rising-edge pulses on pulso_A/pulso_B (tied to 0 otherwise).
module acondicionador_entradas #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic boton_A,
    input  logic boton_B,
    output logic entrada_A,
    output logic entrada_B,
    output logic pulso_A,
    output logic pulso_B,
    output logic estable
);

    typedef enum logic {
        ESTABLE  = 1'b0,
        CONTANDO = 1'b1
    } estado_t;

    localparam logic [15:0] LIMITE = 16'(DEBOUNCE_CYCLES);

    // Index 0 is channel A, index 1 is channel B throughout.
    logic [1:0]  sync_1;
    logic [1:0]  sync_2;
    estado_t     estado      [2];
    estado_t     estado_next [2];
    logic [15:0] cuenta      [2];
    logic [15:0] cuenta_next [2];
    logic [1:0]  salida;
    logic [1:0]  salida_next;
    logic        estable_q;
    logic        estable_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 2'b00;
            sync_2 <= 2'b00;
        end else begin
            sync_1 <= {boton_B, boton_A};
            sync_2 <= sync_1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado[0] <= ESTABLE;
            estado[1] <= ESTABLE;
            cuenta[0] <= 16'd0;
            cuenta[1] <= 16'd0;
            salida    <= 2'b00;
            estable_q <= 1'b1;
        end else begin
            estado[0] <= estado_next[0];
            estado[1] <= estado_next[1];
            cuenta[0] <= cuenta_next[0];
            cuenta[1] <= cuenta_next[1];
            salida    <= salida_next;
            estable_q <= estable_next;
        end
    end

    // The count holds at most DEBOUNCE_CYCLES-1; the edge that would reach the limit toggles instead.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            estado_next[i] = estado[i];
            cuenta_next[i] = cuenta[i];
            salida_next[i] = salida[i];
            case (estado[i])
                ESTABLE: begin
                    if (sync_2[i] != salida[i]) begin
                        estado_next[i] = CONTANDO;
                        cuenta_next[i] = 16'd1;
                    end else begin
                        cuenta_next[i] = 16'd0;
                    end
                end
                CONTANDO: begin
                    if (sync_2[i] == salida[i]) begin
                        estado_next[i] = ESTABLE;
                        cuenta_next[i] = 16'd0;
                    end else if (cuenta[i] + 16'd1 >= LIMITE) begin
                        estado_next[i] = ESTABLE;
                        cuenta_next[i] = 16'd0;
                        salida_next[i] = ~salida[i];
                    end else begin
                        cuenta_next[i] = cuenta[i] + 16'd1;
                    end
                end
                default: begin
                    estado_next[i] = ESTABLE;
                    cuenta_next[i] = 16'd0;
                end
            endcase
        end
    end

    always_comb begin
        estable_next = (estado_next[0] == ESTABLE) && (estado_next[1] == ESTABLE);
    end

    assign entrada_A = salida[0];
    assign entrada_B = salida[1];
    assign estable   = estable_q;

`ifdef ACONDICIONADOR_PULSO_EN
    logic [1:0] pulso_q;
    logic [1:0] pulso_next;

    always_comb begin
        pulso_next = salida_next & ~salida;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulso_q <= 2'b00;
        end else begin
            pulso_q <= pulso_next;
        end
    end

    assign pulso_A = pulso_q[0];
    assign pulso_B = pulso_q[1];
`else
    assign pulso_A = 1'b0;
    assign pulso_B = 1'b0;
`endif

endmodule

// File: tb/tb_acondicionador_entradas.sv
// Directed self-checking bench for acondicionador_entradas with DEBOUNCE_CYCLES=4.
// Expected pulse bits follow ACONDICIONADOR_PULSO_EN as seen by this compilation.
module tb_acondicionador_entradas;

`ifdef ACONDICIONADOR_PULSO_EN
    localparam logic PULSO_EN = 1'b1;
`else
    localparam logic PULSO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic boton_A = 1'b0;
    logic boton_B = 1'b0;
    logic entrada_A, entrada_B, pulso_A, pulso_B, estable;

    int checks = 0;
    int failures = 0;

    acondicionador_entradas #(.DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .boton_A   (boton_A),
        .boton_B   (boton_B),
        .entrada_A (entrada_A),
        .entrada_B (entrada_B),
        .pulso_A   (pulso_A),
        .pulso_B   (pulso_B),
        .estable   (estable)
    );

    always #5 clk = ~clk;

    // Expected vectors per edge, bit order {entrada_A, entrada_B, pulso_A, pulso_B, estable}.
    logic [4:0] tbl_rise_a   [7]  = '{5'b00001, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b10101, 5'b10001};
    logic [4:0] tbl_fall_a   [6]  = '{5'b10001, 5'b10001, 5'b10000, 5'b10000, 5'b10000, 5'b00001};
    logic [4:0] tbl_bounce_b [11] = '{5'b00001, 5'b00001, 5'b00000, 5'b00001, 5'b00000, 5'b00001,
                                      5'b00000, 5'b00000, 5'b00000, 5'b01011, 5'b01001};
    logic [4:0] tbl_fall_b   [6]  = '{5'b01001, 5'b01001, 5'b01000, 5'b01000, 5'b01000, 5'b00001};
    logic [4:0] tbl_both     [7]  = '{5'b00001, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b11111, 5'b11001};
    logic [4:0] tbl_drop_a   [6]  = '{5'b11001, 5'b11001, 5'b11000, 5'b11000, 5'b11000, 5'b01001};
    logic [4:0] tbl_mid_a    [5]  = '{5'b01001, 5'b01001, 5'b01000, 5'b01000, 5'b01000};
    logic [4:0] bounce_b_in  [5]  = '{5'd1, 5'd0, 5'd1, 5'd0, 5'd1};

    task automatic applyStimulus(input logic a, input logic b);
        @(negedge clk);
        boton_A = a;
        boton_B = b;
    endtask

    task automatic checkOutput(input string tag, input int edge_n, input logic [4:0] expected_raw);
        logic [4:0] observed;
        logic [4:0] expected;
        observed = {entrada_A, entrada_B, pulso_A, pulso_B, estable};
        expected = expected_raw & {2'b11, PULSO_EN, PULSO_EN, 1'b1};
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s edge %0d observed=%b expected=%b", tag, edge_n, observed, expected);
        end
    endtask

    task automatic stepAndCheck(input string tag, input int edge_n, input logic [4:0] expected);
        @(posedge clk);
        #1;
        checkOutput(tag, edge_n, expected);
    endtask

    initial begin
        // Reset held across clock edges, then released at a falling edge.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_hold", 0, 5'b00001);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) stepAndCheck("idle", i + 1, 5'b00001);

        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) stepAndCheck("rise_a", i + 1, tbl_rise_a[i]);

        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) stepAndCheck("fall_a", i + 1, tbl_fall_a[i]);

        // B bounces 1,0,1,0 one cycle each, then holds 1.
        for (int i = 0; i < 11; i++) begin
            if (i < 5) applyStimulus(1'b0, bounce_b_in[i][0]);
            stepAndCheck("bounce_b", i + 1, tbl_bounce_b[i]);
        end

        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) stepAndCheck("fall_b", i + 1, tbl_fall_b[i]);

        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 7; i++) stepAndCheck("both_rise", i + 1, tbl_both[i]);

        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) stepAndCheck("drop_a", i + 1, tbl_drop_a[i]);

        // A counting up to 3 while B is high, then reset mid-count.
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) stepAndCheck("mid_a", i + 1, tbl_mid_a[i]);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_async", 0, 5'b00001);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) stepAndCheck("after_reset", i + 1, tbl_both[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
